// File: rtl/serial_adder_pkg.sv
// Shared definitions for serial_adder: FSM state encoding and counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Ceiling log2, but never below 1 so a single-step adder still gets a counter bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational ripple slice of DIGIT full-adder cells; also exposes the carry into
// the top cell so the caller can form signed overflow on the final digit.
module adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             ci_i,
  output logic [DIGIT-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] c;

  always_comb begin
    c[0] = ci_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o    = c[DIGIT];
  assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed DIGIT bits per clock
// through one adder_digit slice, with valid/ready handshakes on input and output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int               STEPS      = WIDTH / DIGIT;
  localparam int               CNT_W      = clog2_min1(STEPS);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(STEPS - 1);
  localparam logic [WIDTH-1:0] DIGIT_MASK = WIDTH'({DIGIT{1'b1}});

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [31:0]      shift;
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             co_dig, c_msb_dig;

  assign shift = 32'(cnt_q) * 32'(DIGIT);
  assign a_dig = DIGIT'(a_q >> shift);
  assign b_dig = DIGIT'(b_q >> shift);

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a_i     (a_dig),
    .b_i     (b_dig),
    .ci_i    (carry_q),
    .s_o     (s_dig),
    .co_o    (co_dig),
    .c_msb_o (c_msb_dig)
  );

  // NOTE: every *_d gets its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + ~cin, so B and the carry are inverted once at accept.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = cin ^ sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = (sum_q & ~(DIGIT_MASK << shift)) | (WIDTH'(s_dig) << shift);
        carry_d = co_dig;
        if (cnt_q == LAST) begin
          cout_d  = co_dig;
          ovf_d   = co_dig ^ c_msb_dig;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are cleared as well; they are plain flops, not a memory, so reset is free.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: several WIDTH/DIGIT instances, directed vectors, backpressure,
// mid-operation reset and randomized handshake traffic against an arithmetic reference.
module tb_serial_adder;

  localparam int NI     = 7;
  localparam int WS [NI] = '{8, 8, 1, 16, 16, 16, 16};
  localparam int DS [NI] = '{1, 4, 1, 1, 2, 4, 16};
  localparam int N_RAND = 250;

  localparam logic [7:0]  VA   [5] = '{8'h05, 8'hFF, 8'h7F, 8'h03, 8'h80};
  localparam logic [7:0]  VB   [5] = '{8'h03, 8'h01, 8'h01, 8'h05, 8'h01};
  localparam logic        VS   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  // {ovf, cout, sum[15:0]}
  localparam logic [17:0] VEXP [5] = '{18'h00008, 18'h10000, 18'h20080, 18'h000FE, 18'h3007F};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [NI];
  logic        out_ready [NI];
  logic        cin_r     [NI];
  logic        sub_r     [NI];
  logic [15:0] a_r       [NI];
  logic [15:0] b_r       [NI];
  wire         in_ready_w  [NI];
  wire         out_valid_w [NI];
  wire         cout_w      [NI];
  wire         ovf_w       [NI];
  wire  [15:0] sum_w       [NI];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = WS[g];
    localparam int D = DS[g];
    logic [W-1:0] s_loc;
    logic         rdy_loc, vld_loc, co_loc, ov_loc;
    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (rdy_loc),
      .a         (a_r[g][W-1:0]),
      .b         (b_r[g][W-1:0]),
      .cin       (cin_r[g]),
      .sub       (sub_r[g]),
      .out_valid (vld_loc),
      .out_ready (out_ready[g]),
      .sum       (s_loc),
      .cout      (co_loc),
      .ovf       (ov_loc)
    );
    assign in_ready_w[g]  = rdy_loc;
    assign out_valid_w[g] = vld_loc;
    assign cout_w[g]      = co_loc;
    assign ovf_w[g]       = ov_loc;
    assign sum_w[g]       = 16'(s_loc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] dut_res(input int k);
    return {ovf_w[k], cout_w[k], sum_w[k]};
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
    longint full, half, ua, ub, sa, sb, u, sres;
    logic   co, ov;
    full = longint'(1) << w;
    half = full >> 1;
    ua   = longint'(a) & (full - 1);
    ub   = longint'(b) & (full - 1);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    if (!sub) begin
      u    = ua + ub + longint'(cin);
      sres = sa + sb + longint'(cin);
      co   = (u >= full);
    end else begin
      u    = ua - ub - longint'(cin);
      sres = sa - sb - longint'(cin);
      co   = (ua >= ub + longint'(cin));
    end
    ov = (sres >= half) || (sres < -half);
    return {ov, co, 16'(u & (full - 1))};
  endfunction

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    while (!out_valid_w[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid_w[k]) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  // One full transaction; operands are scrambled right after accept to prove single sampling.
  task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, output logic [17:0] res, output int lat);
    a_r[k] = a; b_r[k] = b; cin_r[k] = cin; sub_r[k] = sub;
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a_r[k] = 16'($urandom); b_r[k] = 16'($urandom);
    cin_r[k] = 1'($urandom); sub_r[k] = 1'($urandom);
    wait_valid(k, lat);
    res = dut_res(k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic rand_stream(input int k);
    logic [17:0] q[$];
    int n_acc  = 0;
    int n_done = 0;
    int cyc    = 0;
    while ((n_acc < N_RAND || q.size() != 0) && cyc < 20000) begin
      in_valid[k]  = (n_acc < N_RAND) && ($urandom_range(0, 2) != 0);
      out_ready[k] = ($urandom_range(0, 1) == 1);
      a_r[k] = 16'($urandom); b_r[k] = 16'($urandom);
      cin_r[k] = 1'($urandom); sub_r[k] = 1'($urandom);
      if (out_valid_w[k] && out_ready[k]) begin
        check("rand_result_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) check($sformatf("rand_w16_d%0d", DS[k]), 32'(dut_res(k)), 32'(q.pop_front()));
        n_done++;
      end
      if (in_valid[k] && in_ready_w[k]) begin
        q.push_back(ref_model(WS[k], a_r[k], b_r[k], cin_r[k], sub_r[k]));
        n_acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b0;
    check($sformatf("rand_drained_d%0d", DS[k]), 32'(q.size()), 32'd0);
    check($sformatf("rand_count_d%0d", DS[k]), 32'(n_done), 32'(N_RAND));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [17:0] res;
    logic [2:0]  cb;
    int          lat;
    int          seen;

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; cin_r[k] = 1'b0; sub_r[k] = 1'b0;
      a_r[k] = '0; b_r[k] = '0;
    end
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++)
      check($sformatf("reset_state_%0d", k), 32'({in_ready_w[k], out_valid_w[k], dut_res(k)}),
            32'({1'b1, 1'b0, 18'h0}));

    // Directed vectors at DIGIT=1 and DIGIT=4.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        do_op(k, 16'(VA[i]), 16'(VB[i]), 1'b0, VS[i], res, lat);
        check($sformatf("vec%0d_d%0d", i, DS[k]), 32'(res), 32'(VEXP[i]));
        check($sformatf("vec%0d_d%0d_latency", i, DS[k]), 32'(lat), 32'(WS[k] / DS[k]));
      end
    end

    // WIDTH=1: exhaustive {a,b,cin}.
    for (int c = 0; c < 8; c++) begin
      cb = 3'(c);
      do_op(2, 16'(cb[2]), 16'(cb[1]), cb[0], 1'b0, res, lat);
      check($sformatf("w1_combo%0d", c), 32'({res[16], res[0]}), 32'(2'(cb[2]) + 2'(cb[1]) + 2'(cb[0])));
      check($sformatf("w1_combo%0d_latency", c), 32'(lat), 32'd1);
    end

    // Backpressure: result held, new operands ignored until the output handshake.
    a_r[0] = 16'h12; b_r[0] = 16'h34; cin_r[0] = 1'b0; sub_r[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_valid(0, lat);
    a_r[0] = 16'h01; b_r[0] = 16'h02; in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
      check("bp_result_held", 32'({out_valid_w[0], dut_res(0)}), 32'({1'b1, 18'h00046}));
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp_back_idle", 32'({in_ready_w[0], out_valid_w[0], dut_res(0)}), 32'({1'b1, 1'b0, 18'h00046}));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("bp_accepted", 32'(in_ready_w[0]), 32'd0);
    wait_valid(0, lat);
    check("bp_new_result", 32'(dut_res(0)), 32'(18'h00003));
    check("bp_new_latency", 32'(lat), 32'd8);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;

    // Asynchronous reset in the middle of RUN (cnt=3), between clock edges.
    a_r[0] = 16'h5A; b_r[0] = 16'h33; cin_r[0] = 1'b0; sub_r[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("rst_async_state", 32'({in_ready_w[0], out_valid_w[0], dut_res(0)}), 32'({1'b1, 1'b0, 18'h0}));
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid_w[0]) seen++;
    end
    check("rst_no_result", 32'(seen), 32'd0);
    do_op(0, 16'h10, 16'h20, 1'b0, 1'b0, res, lat);
    check("rst_after_result", 32'(res), 32'(18'h00030));
    check("rst_after_latency", 32'(lat), 32'd8);

    // Randomized traffic on all WIDTH=16 instances concurrently.
    fork
      rand_stream(3);
      rand_stream(4);
      rand_stream(5);
      rand_stream(6);
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
